skin_blob_tracker: RTL and testbench
====================================

# skin_blob_tracker

Consumes the per-pixel skin mask stream produced by the skin-thresholding stage and reduces each frame to a single hand descriptor: skin pixel area, centroid and optional bounding box. Sits between the skin mask output and the gesture/arm-control logic. It is the reader side of the mask stream and produces one result record per completed frame.

## Interface
- H_ACTIVE, 640: active pixels per line; max 1023.
- V_ACTIVE, 480: active lines per frame; max 1023; H_ACTIVE*V_ACTIVE must be at least 32 and at most 524287.
- MIN_AREA, 256: minimum skin pixel count for `hand_present`.
- clk  input  1  pixel clock.
- rst  input  1  asynchronous, active-high reset.
- skin_mask  input  1  mask bit, qualified by `valid_in`.
- valid_in  input  1  pixel strobe, one pixel per asserted cycle.
- sof  input  1  start of frame, sampled only when `valid_in`=1; marks that pixel as (0,0).
- area  output  19  skin pixel count of the last completed frame.
- cent_x, cent_y  output  10 each  centroid, truncated integer.
- bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax  output  10 each  inclusive bounding box.
- hand_present  output  1  `area` >= MIN_AREA.
- result_valid  output  1  one-cycle pulse when all result outputs update.
- busy  output  1  divider active.
- frame_err  output  1  one-cycle pulse when `sof` arrives mid-frame.

## Operation
- Pixel counters x (0..H_ACTIVE-1) and y (0..V_ACTIVE-1) advance only on `valid_in`. x wraps to 0 and increments y; at (H_ACTIVE-1, V_ACTIVE-1) both wrap to 0.
- An accepted pixel with `sof`=1 is forced to (0,0) and starts a fresh frame. It clears the accumulators and then adds itself.
- Until the first `sof` after reset, pixels are ignored (state WAIT_SOF). Result generation is armed only once a frame has been started by `sof`.
- Per accepted skin pixel: area_acc += 1; sum_x += x (28 b); sum_y += y (28 b). The bbox min/max are updated (see Configuration). Sums cannot overflow within the parameter limits.
- When the last pixel (H_ACTIVE-1, V_ACTIVE-1) is accepted, the final totals, including that pixel, are snapshotted into divider registers. The accumulators are cleared for the next frame. The FSM goes ACCUM→DIV. Pixels of the next frame keep accumulating in parallel; no stall is required.
- DIV runs two restoring dividers in parallel, sum_x/area and sum_y/area, at one quotient bit per cycle for 28 iterations. The quotients are truncated to 10 b. Divisor 0 gives quotient 0.
- DONE registers all outputs and pulses `result_valid`, then returns to ACCUM.
- If `sof` arrives mid-frame (not at x=0,y=0 in the natural sequence), `frame_err` pulses. The partial frame is discarded with no result, and accumulation restarts. A divide already in flight completes normally.
- If `area`=0: cent_x=cent_y=0, bbox outputs=0, hand_present=0.

## Timing
- Reset: all outputs 0, counters 0, accumulators 0, FSM WAIT_SOF, busy 0.
- Reset asserted mid-frame or mid-divide aborts everything immediately. No `result_valid` follows.
- Edge E0 accepts the last pixel. `busy`=1 from after E0 until after E28. After edge E29, `result_valid`=1 for exactly one cycle, with the new outputs stable from that point until the next update.
- Outputs hold their values between `result_valid` pulses.
- `frame_err` is registered and appears one cycle after the offending `sof` pixel.
- `skin_mask` and `sof` are ignored when `valid_in`=0.

## Configuration
- SKIN_BBOX_EN defined: track per-frame min/max x and y of skin pixels. The min registers reset to 1023 and the max registers to 0 at frame start. Results are published at DONE.
- SKIN_BBOX_EN undefined: no bbox logic is compiled; the bbox outputs are tied to 0. All other behaviour is identical.

## Test plan
- H_ACTIVE=8, V_ACTIVE=8, MIN_AREA=4: `sof` plus 64 pixels with skin only at (2,3),(4,3),(2,5),(4,5) -> area=4, cent_x=3, cent_y=4, bbox 2..4 / 3..5, hand_present=1, `result_valid` pulses 29 edges after the last pixel.
- Same geometry, all-zero mask -> area=0, cent=0, bbox=0, hand_present=0, exactly one `result_valid`.
- Full-skin 640x480 frame with `valid_in` continuously high -> area=307200, cent_x=319, cent_y=239. The next frame accumulates correctly during DIV.
- 8x8 frame with `sof` reasserted at pixel 20 -> `frame_err` pulse, no result for the aborted frame, and the following 64-pixel frame reports correct values.
- Pixels before the first `sof` and with `valid_in` toggling randomly -> pre-`sof` pixels are ignored and the gaps do not change the results.
- `rst` asserted at DIV iteration 10 -> outputs 0 immediately, no `result_valid`, and the tracker waits for `sof`.

Source files
------------

// File: rtl/skin_blob_tracker_if.sv
// skin_blob_tracker_if: per-pixel skin mask stream (mask bit, pixel strobe, start of frame)
interface skin_blob_tracker_if;
  logic skin_mask;
  logic valid_in;
  logic sof;
  modport master(output skin_mask, valid_in, sof);
  modport slave(input skin_mask, valid_in, sof);
endinterface

// File: rtl/skin_blob_tracker.sv
// skin_blob_tracker: reduces each mask frame to skin area, centroid and, with SKIN_BBOX_EN defined,
// a bounding box; published once per completed frame after a 28-cycle restoring divide.
module skin_blob_tracker #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int MIN_AREA = 256
) (
  input  logic               clk,
  input  logic               rst,
  skin_blob_tracker_if.slave pix,
  output logic [18:0]        area,
  output logic [9:0]         cent_x,
  output logic [9:0]         cent_y,
  output logic [9:0]         bbox_xmin,
  output logic [9:0]         bbox_xmax,
  output logic [9:0]         bbox_ymin,
  output logic [9:0]         bbox_ymax,
  output logic               hand_present,
  output logic               result_valid,
  output logic               busy,
  output logic               frame_err
);
  typedef enum logic [1:0] {WAIT_SOF, ACCUM, DIV, DONE} state_t;
  state_t      state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d, px, py, cx_q, cx_d, cy_q, cy_d;
  logic [18:0] acc_q, acc_d, tot_a, dv_q, dv_d, area_q, area_d, rx_q, rx_d, ry_q, ry_d;
  logic [27:0] sx_q, sx_d, sy_q, sy_d, tot_x, tot_y, qx_q, qx_d, qy_q, qy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        take, fresh, skin, last, hp_q, hp_d, rv_q, rv_d, busy_q, busy_d, fe_q, fe_d;

  // one restoring step: remainder stays below the divisor, quotient bits shift in from the right
  function automatic logic [46:0] dstep(input logic [18:0] r, input logic [27:0] q, input logic [18:0] d);
    logic [19:0] t;
    t = {r, q[27]};
    return t >= {1'b0, d} ? {19'(t - {1'b0, d}), q[26:0], 1'b1} : {t[18:0], q[26:0], 1'b0};
  endfunction

  always_comb begin
    take  = pix.valid_in && (pix.sof || state_q != WAIT_SOF);
    fresh = take && pix.sof;
    px    = pix.sof ? '0 : x_q;
    py    = pix.sof ? '0 : y_q;
    skin  = take && pix.skin_mask;
    last  = take && px == 10'(H_ACTIVE - 1) && py == 10'(V_ACTIVE - 1);
    tot_a = (fresh ? '0 : acc_q) + 19'(skin);
    tot_x = (fresh ? '0 : sx_q) + (skin ? 28'(px) : '0);
    tot_y = (fresh ? '0 : sy_q) + (skin ? 28'(py) : '0);
    x_d   = !take ? x_q : px == 10'(H_ACTIVE - 1) ? '0 : px + 10'd1;
    y_d   = !take ? y_q : last ? '0 : px == 10'(H_ACTIVE - 1) ? py + 10'd1 : py;
    acc_d = last ? '0 : tot_a;
    sx_d  = last ? '0 : tot_x;
    sy_d  = last ? '0 : tot_y;
    fe_d  = fresh && state_q != WAIT_SOF && (x_q != '0 || y_q != '0);
    {rx_d, qx_d} = state_q == DIV ? dstep(rx_q, qx_q, dv_q) : {rx_q, qx_q};
    {ry_d, qy_d} = state_q == DIV ? dstep(ry_q, qy_q, dv_q) : {ry_q, qy_q};
    cnt_d   = state_q == DIV ? cnt_q + 5'd1 : cnt_q;
    dv_d    = dv_q;
    state_d = state_q;
    area_d  = area_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    hp_d    = hp_q;
    rv_d    = 1'b0;
    if (last) begin
      state_d = DIV;
      dv_d    = tot_a;
      rx_d    = '0;
      ry_d    = '0;
      qx_d    = tot_x;
      qy_d    = tot_y;
      cnt_d   = '0;
    end else if (state_q == WAIT_SOF && fresh) state_d = ACCUM;
    else if (state_q == DIV && cnt_q == 5'd27) state_d = DONE;
    else if (state_q == DONE) begin
      state_d = ACCUM;
      rv_d    = 1'b1;
      area_d  = dv_q;
      cx_d    = dv_q == '0 ? '0 : qx_q[9:0];
      cy_d    = dv_q == '0 ? '0 : qy_q[9:0];
      hp_d    = dv_q != '0 && dv_q >= 19'(MIN_AREA);
    end
    busy_d = state_d == DIV;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      x_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      dv_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      cnt_q   <= '0;
      area_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      hp_q    <= 1'b0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      dv_q    <= dv_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      cnt_q   <= cnt_d;
      area_q  <= area_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      hp_q    <= hp_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      fe_q    <= fe_d;
    end
  end

  assign area         = area_q;
  assign cent_x       = cx_q;
  assign cent_y       = cy_q;
  assign hand_present = hp_q;
  assign result_valid = rv_q;
  assign busy         = busy_q;
  assign frame_err    = fe_q;

`ifdef SKIN_BBOX_EN
  // packed as {ymax, ymin, xmax, xmin}: running box, end-of-frame snapshot, published box
  localparam logic [3:0][9:0] BB_INIT = {10'd0, 10'd1023, 10'd0, 10'd1023};
  logic [3:0][9:0] bb_q, bb_d, bs_q, bs_d, bo_q, bo_d, bt;

  always_comb begin
    bt = fresh ? BB_INIT : bb_q;
    if (skin) bt = {py > bt[3] ? py : bt[3], py < bt[2] ? py : bt[2], px > bt[1] ? px : bt[1], px < bt[0] ? px : bt[0]};
    bb_d = last ? BB_INIT : bt;
    bs_d = last ? bt : bs_q;
    bo_d = state_q == DONE ? (dv_q == '0 ? '0 : bs_q) : bo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bb_q <= BB_INIT;
      bs_q <= '0;
      bo_q <= '0;
    end else begin
      bb_q <= bb_d;
      bs_q <= bs_d;
      bo_q <= bo_d;
    end
  end

  assign bbox_xmin = bo_q[0];
  assign bbox_xmax = bo_q[1];
  assign bbox_ymin = bo_q[2];
  assign bbox_ymax = bo_q[3];
`else
  assign bbox_xmin = '0;
  assign bbox_xmax = '0;
  assign bbox_ymin = '0;
  assign bbox_ymax = '0;
`endif
endmodule

// File: tb/tb_skin_blob_tracker.sv
// tb_skin_blob_tracker: randomized frames on an 8x8 and a 100x60 tracker against a per-frame arithmetic model
module tb_skin_blob_tracker;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0, e0 = 0, vec = 0, bad = 0, fea = 0, feb = 0;
  always @(posedge clk) cyc <= cyc + 1;

  skin_blob_tracker_if ia(), ib();
  logic [18:0] a_area, b_area;
  logic [9:0]  a_cx, a_cy, a_x0, a_x1, a_y0, a_y1, b_cx, b_cy, b_x0, b_x1, b_y0, b_y1;
  logic        a_hp, a_rv, a_busy, a_fe, b_hp, b_rv, b_busy, b_fe;

  skin_blob_tracker #(.H_ACTIVE(8), .V_ACTIVE(8), .MIN_AREA(4)) dut_a (
    .clk(clk), .rst(rst), .pix(ia), .area(a_area), .cent_x(a_cx), .cent_y(a_cy),
    .bbox_xmin(a_x0), .bbox_xmax(a_x1), .bbox_ymin(a_y0), .bbox_ymax(a_y1),
    .hand_present(a_hp), .result_valid(a_rv), .busy(a_busy), .frame_err(a_fe));
  skin_blob_tracker #(.H_ACTIVE(100), .V_ACTIVE(60), .MIN_AREA(256)) dut_b (
    .clk(clk), .rst(rst), .pix(ib), .area(b_area), .cent_x(b_cx), .cent_y(b_cy),
    .bbox_xmin(b_x0), .bbox_xmax(b_x1), .bbox_ymin(b_y0), .bbox_ymax(b_y1),
    .hand_present(b_hp), .result_valid(b_rv), .busy(b_busy), .frame_err(b_fe));

  bit fr [6000];
  logic [79:0] qa[$], qb[$];
  int ta[$];

  function automatic logic [79:0] obs_a();
    return {a_area, a_cx, a_cy, a_x0, a_x1, a_y0, a_y1, a_hp};
  endfunction
  function automatic logic [79:0] obs_b();
    return {b_area, b_cx, b_cy, b_x0, b_x1, b_y0, b_y1, b_hp};
  endfunction

  always @(negedge clk) begin
    if (a_rv) begin qa.push_back(obs_a()); ta.push_back(cyc); end
    if (b_rv) qb.push_back(obs_b());
    if (a_fe) fea++;
    if (b_fe) feb++;
  end

  // expected frame record from the mask in raster order: x = i mod h, y = i div h
  function automatic logic [79:0] model(input int h, input int v, input int mina);
    longint a = 0, sx = 0, sy = 0;
    int x0 = 1023, x1 = 0, y0 = 1023, y1 = 0;
    for (int i = 0; i < h * v; i++) if (fr[i]) begin
      a++;
      sx += i % h;
      sy += i / h;
      if (i % h < x0) x0 = i % h;
      if (i % h > x1) x1 = i % h;
      if (i / h < y0) y0 = i / h;
      if (i / h > y1) y1 = i / h;
    end
    if (a == 0) return '0;
`ifndef SKIN_BBOX_EN
    x0 = 0; x1 = 0; y0 = 0; y1 = 0;
`endif
    return {19'(a), 10'(sx / a), 10'(sy / a), 10'(x0), 10'(x1), 10'(y0), 10'(y1), a >= longint'(mina)};
  endfunction

  task automatic fill(input int n, input int pct);
    for (int i = 0; i < n; i++) fr[i] = $urandom_range(99) < pct;
  endtask

  task automatic drv(input bit sel, input bit v, input bit m, input bit s);
    if (sel) begin ib.valid_in = v; ib.skin_mask = m; ib.sof = s; end
    else begin ia.valid_in = v; ia.skin_mask = m; ia.sof = s; end
  endtask

  task automatic send(input bit sel, input int lo, input int hi, input int gap, input bit s0);
    for (int i = lo; i < hi; i++) begin
      while ($urandom_range(99) < gap) begin
        drv(sel, 1'b0, 1'($urandom), 1'($urandom));
        @(posedge clk); #1;
      end
      drv(sel, 1'b1, fr[i], s0 && i == lo);
      @(posedge clk); #1;
    end
    drv(sel, 1'b0, 1'b0, 1'b0);
    e0 = cyc;
  endtask

  task automatic wait_q(input bit sel, input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if ((sel ? qb.size() : qa.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vec++; if (obs_a() !== '0) begin bad++; $display("FAIL reset_a_outputs got %h exp 0", obs_a()); end
    vec++; if ({a_busy, a_rv, a_fe} !== 3'b000) begin bad++; $display("FAIL reset_a_flags got %b exp 000", {a_busy, a_rv, a_fe}); end
    vec++; if ({obs_b(), b_busy, b_rv, b_fe} !== '0) begin bad++; $display("FAIL reset_b got %h exp 0", {obs_b(), b_busy, b_rv, b_fe}); end
    rst = 1'b0;
  endtask

  task automatic test_centroid();
    int n0 = qa.size();
    logic [79:0] exp;
    for (int i = 0; i < 64; i++) fr[i] = 1'b0;
    fr[26] = 1'b1; fr[28] = 1'b1; fr[42] = 1'b1; fr[44] = 1'b1;
    exp = model(8, 8, 4);
    send(0, 0, 64, 0, 1'b1);
    vec++; if (a_busy !== 1'b1) begin bad++; $display("FAIL busy_after_e0 got %b exp 1", a_busy); end
    repeat (27) begin @(posedge clk); #1; end
    vec++; if (a_busy !== 1'b1) begin bad++; $display("FAIL busy_e27 got %b exp 1", a_busy); end
    @(posedge clk); #1;
    vec++; if ({a_busy, a_rv} !== 2'b00) begin bad++; $display("FAIL busy_rv_e28 got %b exp 00", {a_busy, a_rv}); end
    wait_q(0, n0 + 1, 10);
    vec++;
    if (qa.size() != n0 + 1) begin bad++; $display("FAIL cent_result_count got %0d exp %0d", qa.size(), n0 + 1); end
    else begin
      vec++; if (qa[n0] !== exp) begin bad++; $display("FAIL cent_record got %h exp %h", qa[n0], exp); end
      vec++; if (ta[n0] - e0 != 29) begin bad++; $display("FAIL cent_latency got %0d exp 29", ta[n0] - e0); end
      vec++; if ({a_area, a_cx, a_cy} !== {19'd4, 10'd3, 10'd4}) begin bad++; $display("FAIL cent_values got %h exp %h", {a_area, a_cx, a_cy}, {19'd4, 10'd3, 10'd4}); end
    end
  endtask

  task automatic test_empty();
    int n0 = qa.size();
    for (int i = 0; i < 64; i++) fr[i] = 1'b0;
    send(0, 0, 64, 0, 1'b1);
    wait_q(0, n0 + 1, 40);
    repeat (40) @(posedge clk);
    #1;
    vec++;
    if (qa.size() != n0 + 1) begin bad++; $display("FAIL empty_result_count got %0d exp %0d", qa.size(), n0 + 1); end
    else begin
      vec++; if (qa[n0] !== '0) begin bad++; $display("FAIL empty_record got %h exp 0", qa[n0]); end
    end
  endtask

  task automatic test_min_area();
    for (int k = 3; k <= 4; k++) begin
      int n0 = qa.size();
      int j = 0;
      logic [79:0] exp;
      for (int i = 0; i < 64; i++) fr[i] = 1'b0;
      while (j < k) begin
        int p = $urandom_range(63);
        if (!fr[p]) begin fr[p] = 1'b1; j++; end
      end
      exp = model(8, 8, 4);
      send(0, 0, 64, $urandom_range(30), 1'b1);
      wait_q(0, n0 + 1, 40);
      vec++;
      if (qa.size() != n0 + 1) begin bad++; $display("FAIL min_area_count k=%0d got %0d exp %0d", k, qa.size(), n0 + 1); end
      else begin
        vec++; if (qa[n0] !== exp) begin bad++; $display("FAIL min_area_record k=%0d got %h exp %h", k, qa[n0], exp); end
        vec++; if (qa[n0][0] !== (k == 4)) begin bad++; $display("FAIL hand_present k=%0d got %b exp %b", k, qa[n0][0], k == 4); end
      end
    end
  endtask

  task automatic test_frame_err();
    int n0, f0;
    logic [79:0] exp;
    fill(64, 50);
    send(0, 0, 20, 0, 1'b1);
    fill(64, 50);
    exp = model(8, 8, 4);
    n0 = qa.size();
    f0 = fea;
    drv(0, 1'b1, fr[0], 1'b1);
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b0, 1'b0);
    vec++; if (a_fe !== 1'b1) begin bad++; $display("FAIL frame_err_set got %b exp 1", a_fe); end
    @(posedge clk); #1;
    vec++; if (a_fe !== 1'b0) begin bad++; $display("FAIL frame_err_width got %b exp 0", a_fe); end
    send(0, 1, 64, 20, 1'b0);
    wait_q(0, n0 + 1, 40);
    repeat (40) @(posedge clk);
    #1;
    vec++;
    if (qa.size() != n0 + 1) begin bad++; $display("FAIL restart_count got %0d exp %0d", qa.size(), n0 + 1); end
    else begin
      vec++; if (qa[n0] !== exp) begin bad++; $display("FAIL restart_record got %h exp %h", qa[n0], exp); end
    end
    vec++; if (fea - f0 != 1) begin bad++; $display("FAIL frame_err_count got %0d exp 1", fea - f0); end
  endtask

  task automatic test_back_to_back();
    logic [79:0] e [3];
    int n0, f0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = qa.size();
    f0 = fea;
    for (int i = 0; i < 70; i++) begin drv(0, 1'b1, 1'b1, 1'b0); @(posedge clk); #1; end
    drv(0, 1'b0, 1'b0, 1'b0);
    repeat (35) @(posedge clk);
    #1;
    vec++; if (qa.size() != n0 || a_busy !== 1'b0) begin bad++; $display("FAIL pre_sof got results=%0d busy=%b exp results=%0d busy=0", qa.size(), a_busy, n0); end
    for (int k = 0; k < 3; k++) begin
      fill(64, $urandom_range(100));
      e[k] = model(8, 8, 4);
      send(0, 0, 64, 40, 1'b1);
    end
    wait_q(0, n0 + 3, 60);
    vec++;
    if (qa.size() != n0 + 3) begin bad++; $display("FAIL b2b_count got %0d exp %0d", qa.size(), n0 + 3); end
    else for (int k = 0; k < 3; k++) begin
      vec++; if (qa[n0 + k] !== e[k]) begin bad++; $display("FAIL b2b_record%0d got %h exp %h", k, qa[n0 + k], e[k]); end
    end
    vec++; if (fea != f0) begin bad++; $display("FAIL b2b_frame_err got %0d exp 0", fea - f0); end
  endtask

  task automatic test_full();
    int n0 = qb.size();
    logic [79:0] e1, e2;
    for (int i = 0; i < 6000; i++) fr[i] = 1'b1;
    e1 = model(100, 60, 256);
    send(1, 0, 6000, 0, 1'b1);
    fill(6000, 30);
    e2 = model(100, 60, 256);
    send(1, 0, 6000, 0, 1'b1);
    wait_q(1, n0 + 2, 100);
    vec++;
    if (qb.size() != n0 + 2) begin bad++; $display("FAIL full_count got %0d exp %0d", qb.size(), n0 + 2); end
    else begin
      vec++; if (qb[n0] !== e1) begin bad++; $display("FAIL full_record got %h exp %h", qb[n0], e1); end
      vec++; if (qb[n0][79:41] !== {19'd6000, 10'd49, 10'd29}) begin bad++; $display("FAIL full_values got %h exp %h", qb[n0][79:41], {19'd6000, 10'd49, 10'd29}); end
      vec++; if (qb[n0 + 1] !== e2) begin bad++; $display("FAIL overlap_record got %h exp %h", qb[n0 + 1], e2); end
    end
    vec++; if (feb != 0) begin bad++; $display("FAIL full_frame_err got %0d exp 0", feb); end
  endtask

  task automatic test_reset_div();
    int n0 = qa.size();
    logic [79:0] exp;
    for (int i = 0; i < 64; i++) fr[i] = 1'b0;
    fr[9] = 1'b1; fr[18] = 1'b1; fr[63] = 1'b1; fr[40] = 1'b1; fr[41] = 1'b1;
    exp = model(8, 8, 4);
    send(0, 0, 64, 0, 1'b1);
    wait_q(0, n0 + 1, 40);
    vec++; if (obs_a() !== exp) begin bad++; $display("FAIL rdiv_before got %h exp %h", obs_a(), exp); end
    send(0, 0, 64, 0, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    vec++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rdiv_busy got %b exp 1", a_busy); end
    rst = 1'b1;
    #1;
    vec++; if ({obs_a(), a_busy, a_rv, a_fe} !== '0) begin bad++; $display("FAIL rdiv_clear got %h exp 0", {obs_a(), a_busy, a_rv, a_fe}); end
    @(posedge clk); #1;
    rst = 1'b0;
    n0 = qa.size();
    send(0, 0, 64, 10, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    vec++; if (qa.size() != n0 || obs_a() !== '0) begin bad++; $display("FAIL rdiv_no_result got %0d/%h exp %0d/0", qa.size(), obs_a(), n0); end
    send(0, 0, 64, 0, 1'b1);
    wait_q(0, n0 + 1, 40);
    vec++;
    if (qa.size() != n0 + 1) begin bad++; $display("FAIL rdiv_resume_count got %0d exp %0d", qa.size(), n0 + 1); end
    else begin
      vec++; if (qa[n0] !== exp) begin bad++; $display("FAIL rdiv_resume got %h exp %h", qa[n0], exp); end
    end
  endtask

  initial begin
    drv(0, 1'b0, 1'b0, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_centroid();
    test_empty();
    test_min_area();
    test_frame_err();
    test_back_to_back();
    test_full();
    test_reset_div();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d exp finish earlier", cyc);
    $fatal(1);
  end
endmodule
